// File: rtl/seg_scan_driver.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : seg_scan_driver                                              |
// | Brief   : Eight-digit multiplexed seven-segment driver with frame-     |
// |           aligned (tear-free) update of value, blank and DP masks.     |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module seg_scan_driver #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [7:0]  blank_mask,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  SEG,
    output logic [7:0]  AN,
    output logic        frame_tick
);

    localparam int                 c_DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic [2:0]         r_idx;
    logic [31:0]        r_pend_data;
    logic [7:0]         r_pend_blank;
    logic [7:0]         r_pend_dp;
    logic               r_pend_valid;
    logic [31:0]        r_disp_data;
    logic [7:0]         r_disp_blank;
    logic [7:0]         r_disp_dp;

    logic               w_slot_end;
    logic               w_commit;
    logic [3:0]         w_digit;
    logic [6:0]         w_seg;

    assign w_slot_end = (r_div_cnt == c_DIV_LAST);
    assign w_commit   = w_slot_end && (r_idx == 3'd7);
    assign w_digit    = r_disp_data[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_seg = 7'h7F;
        case (w_digit)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            4'hF: w_seg = 7'h0E;
            default: w_seg = 7'h7F;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt    <= '0;
            r_idx        <= 3'd0;
            r_pend_data  <= 32'd0;
            r_pend_blank <= 8'd0;
            r_pend_dp    <= 8'd0;
            r_pend_valid <= 1'b0;
            r_disp_data  <= 32'd0;
            r_disp_blank <= 8'd0;
            r_disp_dp    <= 8'd0;
            SEG          <= 8'hFF;
            AN           <= 8'hFF;
            frame_tick   <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_div_cnt <= '0;
                r_idx     <= r_idx + 3'd1;
            end else begin
                r_div_cnt <= r_div_cnt + c_DIV_ONE;
            end

            // A load on the commit edge lands in pending; the commit below
            // still sees the previous pending contents.
            if (load) begin
                r_pend_data  <= data;
                r_pend_blank <= blank_mask;
                r_pend_dp    <= dp_mask;
                r_pend_valid <= 1'b1;
            end else if (w_commit) begin
                r_pend_valid <= 1'b0;
            end

            if (w_commit && r_pend_valid) begin
                r_disp_data  <= r_pend_data;
                r_disp_blank <= r_pend_blank;
                r_disp_dp    <= r_pend_dp;
            end

            frame_tick <= w_commit;
            AN         <= r_disp_blank[r_idx] ? 8'hFF : ~(8'h01 << r_idx);
            SEG        <= {~r_disp_dp[r_idx], w_seg};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_seg_scan_driver                                           |
// | Brief   : Self-checking bench for seg_scan_driver (SCAN_DIV 4 and 1).  |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] data;
    logic [7:0]  blank_mask;
    logic [7:0]  dp_mask;
    logic [7:0]  seg0, an0, seg1, an1;
    logic        ft0, ft1;

    int total = 0;
    int bad   = 0;
    int n     = 0;   // rising edges since reset released; 0 while in reset

    typedef struct {
        int          n;
        logic [31:0] d;
        logic [7:0]  b;
        logic [7:0]  p;
    } ld_t;
    ld_t loads[$];

    always #5 clk = ~clk;

    seg_scan_driver #(.SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load), .data(data),
        .blank_mask(blank_mask), .dp_mask(dp_mask),
        .SEG(seg0), .AN(an0), .frame_tick(ft0)
    );

    seg_scan_driver #(.SCAN_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .load(load), .data(data),
        .blank_mask(blank_mask), .dp_mask(dp_mask),
        .SEG(seg1), .AN(an1), .frame_tick(ft1)
    );

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    // Expected {frame_tick, AN, SEG} right after edge n for a given SCAN_DIV.
    // A load taken at edge m becomes visible once the first frame boundary
    // strictly after m has passed: boundary = (m / frame + 1) * frame.
    function automatic logic [16:0] exp_out(input int en, input int d);
        int          f = 8 * d;
        int          k;
        logic [31:0] vd = 0;
        logic [7:0]  vb = 0, vp = 0, a;
        logic [6:0]  s;
        if (en == 0) return {1'b0, 8'hFF, 8'hFF};
        k = ((en - 1) / d) % 8;
        foreach (loads[i])
            if ((loads[i].n / f + 1) * f < en) begin
                vd = loads[i].d; vb = loads[i].b; vp = loads[i].p;
            end
        a = vb[k] ? 8'hFF : ~(8'h01 << k);
        s = hex7(vd[k*4 +: 4]);
        return {(en % f) == 0, a, ~vp[k], s};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            n = 0;
            loads.delete();
        end else begin
            n++;
            if (load) loads.push_back('{n, data, blank_mask, dp_mask});
        end
        #1;
    endtask

    task automatic pulse_load(input logic [31:0] d, input logic [7:0] b, input logic [7:0] p);
        data = d; blank_mask = b; dp_mask = p; load = 1'b1;
        tick();
        load = 1'b0;
        total++;
        if ({ft0, an0, seg0} !== exp_out(n, 4)) begin
            bad++;
            $display("FAIL load_cycle n=%0d got=%h want=%h", n, {ft0, an0, seg0}, exp_out(n, 4));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1;
        data = $urandom; blank_mask = 8'h00; dp_mask = 8'hFF;
        repeat (3) begin
            tick();
            total++;
            if ({ft0, an0, seg0, ft1, an1, seg1} !== {1'b0, 16'hFFFF, 1'b0, 16'hFFFF}) begin
                bad++;
                $display("FAIL reset_hold got ft/AN/SEG=%b/%h/%h div1=%b/%h/%h want 0/ff/ff",
                         ft0, an0, seg0, ft1, an1, seg1);
            end
        end
        rst = 1'b0; load = 1'b0;
        tick();
        total++;
        if (an0 !== 8'hFE || seg0 !== 8'hC0 || an1 !== 8'hFE || seg1 !== 8'hC0) begin
            bad++;
            $display("FAIL reset_release got AN=%h SEG=%h div1 AN=%h SEG=%h want fe/c0", an0, seg0, an1, seg1);
        end
        // The load held during reset must never surface.
        repeat (40) begin
            tick();
            total++;
            if ({ft0, an0, seg0} !== exp_out(n, 4) || seg0 !== 8'hC0) begin
                bad++;
                $display("FAIL reset_load_lost n=%0d got=%h want=%h", n, {ft0, an0, seg0}, exp_out(n, 4));
            end
        end
    endtask

    task automatic test_scan_decode();
        logic [7:0] an_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        logic [7:0] sg_tab [8] = '{8'h8E, 8'h88, 8'h90, 8'h80, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
        int w = 0;
        pulse_load(32'h0123_89AF, 8'h00, 8'h00);
        do begin tick(); w++; end while (ft0 !== 1'b1 && w < 40);
        total++;
        if (ft0 !== 1'b1) begin bad++; $display("FAIL scan_wait_tick got=0 want=1"); end
        for (int i = 0; i < 32; i++) begin
            tick();
            total++;
            if (an0 !== an_tab[i/4] || seg0 !== sg_tab[i/4] || {ft0, an0, seg0} !== exp_out(n, 4)) begin
                bad++;
                $display("FAIL scan_decode step=%0d got AN=%h SEG=%h want AN=%h SEG=%h",
                         i, an0, seg0, an_tab[i/4], sg_tab[i/4]);
            end
        end
    endtask

    task automatic test_deferred();
        int w = 0;
        pulse_load(32'h0000_0000, 8'h00, 8'h00);
        repeat (40) tick();
        while (n % 32 != 12) tick();
        pulse_load(32'hFFFF_FFFF, 8'h00, 8'h00);
        do begin
            tick(); w++;
            total++;
            if (seg0 !== 8'hC0) begin
                bad++;
                $display("FAIL deferred_old n=%0d got SEG=%h want c0", n, seg0);
            end
        end while (ft0 !== 1'b1 && w < 40);
        for (int i = 0; i < 32; i++) begin
            tick();
            total++;
            if (seg0 !== 8'h8E || {ft0, an0, seg0} !== exp_out(n, 4)) begin
                bad++;
                $display("FAIL deferred_new step=%0d got=%h want=%h", i, {ft0, an0, seg0}, exp_out(n, 4));
            end
        end
    endtask

    task automatic test_load_on_commit();
        pulse_load(32'h1111_1111, 8'h00, 8'h00);
        while (n % 32 != 31) tick();
        data = 32'h2222_2222; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            total++;
            if (seg0 !== (i < 32 ? 8'hF9 : 8'hA4) || ft0 !== (i % 32 == 31) ||
                {ft0, an0, seg0} !== exp_out(n, 4)) begin
                bad++;
                $display("FAIL commit_edge step=%0d got ft=%b SEG=%h want ft=%b SEG=%h",
                         i, ft0, seg0, (i % 32 == 31), (i < 32 ? 8'hF9 : 8'hA4));
            end
        end
    endtask

    task automatic test_masks();
        int w = 0;
        pulse_load($urandom, 8'h81, 8'h02);
        do tick(); while (ft0 !== 1'b1 && ++w < 40);
        for (int i = 0; i < 32; i++) begin
            int          k = i / 4;
            logic [7:0]  a = (k == 0 || k == 7) ? 8'hFF : ~(8'h01 << k);
            tick();
            total++;
            if (an0 !== a || seg0[7] !== (k != 1) || ft0 !== (i == 31) ||
                {ft0, an0, seg0} !== exp_out(n, 4)) begin
                bad++;
                $display("FAIL masks step=%0d got ft=%b AN=%h DP=%b want ft=%b AN=%h DP=%b",
                         i, ft0, an0, seg0[7], (i == 31), a, (k != 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        while (n % 32 != 20) tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (an0 !== 8'hFE || seg0 !== 8'hC0) begin
            bad++;
            $display("FAIL reset_mid got AN=%h SEG=%h want fe/c0", an0, seg0);
        end
        for (int i = 0; i < 36; i++) begin
            tick();
            total++;
            if (ft0 !== (n == 32) || {ft0, an0, seg0} !== exp_out(n, 4)) begin
                bad++;
                $display("FAIL reset_mid_frame n=%0d got=%h want=%h", n, {ft0, an0, seg0}, exp_out(n, 4));
            end
        end
    endtask

    task automatic test_scan_div1();
        for (int i = 0; i < 24; i++) begin
            if (i == 5) pulse_load($urandom, $urandom, $urandom);
            else tick();
            total++;
            if (ft1 !== (n % 8 == 0) || {ft1, an1, seg1} !== exp_out(n, 1)) begin
                bad++;
                $display("FAIL div1 n=%0d got=%h want=%h", n, {ft1, an1, seg1}, exp_out(n, 1));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 900; i++) begin
            rst  = ($urandom_range(0, 299) == 0);
            load = ($urandom_range(0, 19) == 0);
            data = $urandom; blank_mask = $urandom; dp_mask = $urandom;
            tick();
            load = 1'b0;
            rst  = 1'b0;
            total++;
            if ({ft0, an0, seg0} !== exp_out(n, 4) || {ft1, an1, seg1} !== exp_out(n, 1)) begin
                bad++;
                $display("FAIL random n=%0d got=%h/%h want=%h/%h", n,
                         {ft0, an0, seg0}, {ft1, an1, seg1}, exp_out(n, 4), exp_out(n, 1));
            end
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; data = '0; blank_mask = '0; dp_mask = '0;
        test_reset();
        test_scan_decode();
        test_deferred();
        test_load_on_commit();
        test_masks();
        test_reset_mid();
        test_scan_div1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
